run_controller: RTL and testbench

//  Synthesizable run-control and watchdog unit for the mp4 top level.

---
 rtl/run_controller_if.sv | 31 +++
 rtl/run_controller.sv | 137 +++++++++++++
 tb/tb_run_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/run_controller_if.sv
// Bundles the run-control inputs (limits, monitor strobes) and the controller status outputs.
// The master side drives limits and strobes; the slave side (run_controller) reports status.
interface run_controller_if #(
  parameter int N_ERR    = 2,
  parameter int N_COMMIT = 1,
  parameter int CNT_W    = 32,
  parameter int HANG_W   = 16
);
  logic [CNT_W-1:0]    timeout_limit;
  logic [HANG_W-1:0]   hang_limit;
  logic                halt;
  logic [N_COMMIT-1:0] commit_valid;
  logic [N_ERR-1:0]    err;

  logic                dut_rst;
  logic                finish;
  logic [2:0]          end_cause;
  logic [N_ERR-1:0]    err_src;
  logic [CNT_W-1:0]    cycle_count;
  logic [31:0]         commit_count;

  modport master (
    output timeout_limit, hang_limit, halt, commit_valid, err,
    input  dut_rst, finish, end_cause, err_src, cycle_count, commit_count
  );

  modport slave (
    input  timeout_limit, hang_limit, halt, commit_valid, err,
    output dut_rst, finish, end_cause, err_src, cycle_count, commit_count
  );
endinterface

// File: rtl/run_controller.sv
// Run-control / watchdog: sequences DUT reset, counts cycles and retirements, and ends the run
// on halt, error (after a drain window), global timeout or commit starvation.
module run_controller #(
  parameter int RESET_CYCLES = 2,
  parameter int DRAIN_CYCLES = 5,
  parameter int N_ERR        = 2,
  parameter int N_COMMIT     = 1,
  parameter int CNT_W        = 32,
  parameter int HANG_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  run_controller_if.slave bus
);
  localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
  localparam int DRN_W  = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] CAUSE_RUN     = 3'd0;
  localparam logic [2:0] CAUSE_HALT    = 3'd1;
  localparam logic [2:0] CAUSE_ERROR   = 3'd2;
  localparam logic [2:0] CAUSE_TIMEOUT = 3'd3;
  localparam logic [2:0] CAUSE_HANG    = 3'd4;

  typedef enum logic [1:0] {S_HOLD, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DRN_W-1:0]  drain_cnt;
  logic              dut_rst_q;
  logic              finish_q;
  logic [2:0]        cause_q;
  logic [N_ERR-1:0]  err_src_q;
  logic [CNT_W-1:0]  cyc_q;
  logic [31:0]       commit_q;
  logic [HANG_W-1:0] hang_q;

  logic [3:0]        n_commit;
  logic              any_commit;
  logic [CNT_W-1:0]  cyc_inc;
  logic [HANG_W-1:0] hang_inc;
  logic [CNT_W:0]    cyc_nxt;
  logic [HANG_W:0]   hang_nxt;
  logic              timeout_hit;
  logic              hang_hit;

  always_comb begin
    n_commit = '0;
    for (int i = 0; i < N_COMMIT; i++) n_commit = n_commit + 4'(bus.commit_valid[i]);
  end

  assign any_commit = |bus.commit_valid;
  assign cyc_inc    = (cyc_q == '1) ? cyc_q : cyc_q + CNT_W'(1);
  assign hang_inc   = (hang_q == '1) ? hang_q : hang_q + HANG_W'(1);

  // Compare one bit wider so a saturated counter never aliases onto a small limit.
  assign cyc_nxt     = {1'b0, cyc_q} + (CNT_W+1)'(1);
  assign hang_nxt    = {1'b0, hang_q} + (HANG_W+1)'(1);
  assign timeout_hit = (bus.timeout_limit != '0) && (cyc_nxt == {1'b0, bus.timeout_limit});
  assign hang_hit    = (bus.hang_limit != '0) && !any_commit &&
                       (hang_nxt == {1'b0, bus.hang_limit});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      drain_cnt <= '0;
      dut_rst_q <= 1'b1;
      finish_q  <= 1'b0;
      cause_q   <= CAUSE_RUN;
      err_src_q <= '0;
      cyc_q     <= '0;
      commit_q  <= '0;
      hang_q    <= '0;
    end else begin
      unique case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_W'(RESET_CYCLES - 1)) begin
            state     <= S_RUN;
            dut_rst_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          cyc_q    <= cyc_inc;
          commit_q <= commit_q + 32'(n_commit);
          hang_q   <= any_commit ? '0 : hang_inc;
          if (|bus.err) begin
            err_src_q <= bus.err;
            if (DRAIN_CYCLES == 0) begin
              state    <= S_DONE;
              finish_q <= 1'b1;
              cause_q  <= CAUSE_ERROR;
            end else begin
              state     <= S_DRAIN;
              drain_cnt <= DRN_W'(1);
            end
          end else if (bus.halt) begin
            state    <= S_DONE;
            finish_q <= 1'b1;
            cause_q  <= CAUSE_HALT;
          end else if (timeout_hit) begin
            state    <= S_DONE;
            finish_q <= 1'b1;
            cause_q  <= CAUSE_TIMEOUT;
          end else if (hang_hit) begin
            state    <= S_DONE;
            finish_q <= 1'b1;
            cause_q  <= CAUSE_HANG;
          end
        end
        S_DRAIN: begin
          // Late error sources are still collected so the report shows everything that fired.
          cyc_q     <= cyc_inc;
          commit_q  <= commit_q + 32'(n_commit);
          err_src_q <= err_src_q | bus.err;
          if (drain_cnt == DRN_W'(DRAIN_CYCLES)) begin
            state    <= S_DONE;
            finish_q <= 1'b1;
            cause_q  <= CAUSE_ERROR;
          end else begin
            drain_cnt <= drain_cnt + DRN_W'(1);
          end
        end
        S_DONE: begin
        end
      endcase
    end
  end

  assign bus.dut_rst      = dut_rst_q;
  assign bus.finish       = finish_q;
  assign bus.end_cause    = cause_q;
  assign bus.err_src      = err_src_q;
  assign bus.cycle_count  = cyc_q;
  assign bus.commit_count = commit_q;
endmodule

// File: tb/tb_run_controller.sv
// Randomized runs against a cycle-indexed reference model; expected end-of-run records are
// queued by the driver and checked by a monitor when finish rises.
module tb_run_controller;
  localparam int RESET_CYCLES = 2;
  localparam int DRAIN_CYCLES = 5;
  localparam int N_ERR        = 2;
  localparam int N_COMMIT     = 2;
  localparam int CNT_W        = 32;
  localparam int HANG_W       = 16;
  localparam int NRUNS        = 40;

  typedef struct {
    int cause;
    int cyc;
    int commits;
    int src;
    int edge_idx;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  run_controller_if #(.N_ERR(N_ERR), .N_COMMIT(N_COMMIT), .CNT_W(CNT_W), .HANG_W(HANG_W)) bus ();

  run_controller #(
    .RESET_CYCLES(RESET_CYCLES), .DRAIN_CYCLES(DRAIN_CYCLES), .N_ERR(N_ERR),
    .N_COMMIT(N_COMMIT), .CNT_W(CNT_W), .HANG_W(HANG_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N_COMMIT-1:0] cv, input logic [N_ERR-1:0] e, input logic h,
                       input int tl, input int hl);
    bus.commit_valid  = cv;
    bus.err           = e;
    bus.halt          = h;
    bus.timeout_limit = CNT_W'(tl);
    bus.hang_limit    = HANG_W'(hl);
  endtask

  // Monitor: counts edges since rst release and checks a queued record on each finish rise.
  int   mon_edge = 0;
  logic mon_prev = 1'b0;
  initial begin
    exp_t ex;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mon_edge = 0;
        mon_prev = 1'b0;
      end else begin
        mon_edge++;
        if (bus.finish && !mon_prev) begin
          if (q.size() == 0) begin
            chk("unexpected_finish", longint'(bus.finish), 0);
          end else begin
            ex = q.pop_front();
            chk("end_cause",    longint'(bus.end_cause), ex.cause);
            chk("cycle_count",  longint'(bus.cycle_count), ex.cyc);
            chk("commit_count", longint'(bus.commit_count), ex.commits);
            chk("err_src",      longint'(bus.err_src), ex.src);
            chk("finish_edge",  mon_edge, ex.edge_idx);
          end
        end
        mon_prev = bus.finish;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, err_at, commits, idle, src, cause, tl, hl, p_halt, p_err, p_cm, waitc;
    bit done, abort, aborted;
    logic [N_COMMIT-1:0] cv;
    logic [N_ERR-1:0]    e;
    logic                h;
    exp_t ex;

    drive('0, '0, 1'b0, 0, 0);
    for (int r = 0; r < NRUNS; r++) begin
      rst = 1'b0;
      drive('0, '0, 1'b0, 0, 0);
      repeat (3) @(negedge clk);
      chk("rst_dut_rst",   longint'(bus.dut_rst), 1);
      chk("rst_finish",    longint'(bus.finish), 0);
      chk("rst_cause",     longint'(bus.end_cause), 0);
      chk("rst_err_src",   longint'(bus.err_src), 0);
      chk("rst_cycles",    longint'(bus.cycle_count), 0);
      chk("rst_commits",   longint'(bus.commit_count), 0);

      tl     = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(15, 120));
      hl     = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 10));
      p_halt = int'($urandom_range(0, 4));
      p_err  = int'($urandom_range(0, 4));
      p_cm   = int'($urandom_range(0, 100));
      abort  = ($urandom_range(0, 4) == 0);

      rst = 1'b1;
      @(negedge clk);
      chk("hold_dut_rst", longint'(bus.dut_rst), 1);
      @(negedge clk);
      chk("run_dut_rst", longint'(bus.dut_rst), 0);
      chk("run_cause",   longint'(bus.end_cause), 0);

      k = 0; err_at = 0; commits = 0; idle = 0; src = 0; cause = 0;
      done = 1'b0; aborted = 1'b0;
      while (!done) begin
        k++;
        for (int i = 0; i < N_COMMIT; i++) cv[i] = ($urandom_range(0, 99) < p_cm);
        e = ($urandom_range(0, 99) < p_err) ? N_ERR'($urandom_range(1, 3)) : '0;
        h = (k >= 300) || ($urandom_range(0, 99) < p_halt);
        drive(cv, e, h, tl, hl);

        commits += $countones(cv);
        if (err_at == 0) begin
          idle = (cv != 0) ? 0 : idle + 1;
          if (e != 0) begin
            err_at = k;
            src    = int'(e);
            if (DRAIN_CYCLES == 0) begin done = 1'b1; cause = 2; end
          end else if (h) begin
            done = 1'b1; cause = 1;
          end else if (tl != 0 && k == tl) begin
            done = 1'b1; cause = 3;
          end else if (hl != 0 && idle == hl) begin
            done = 1'b1; cause = 4;
          end
        end else begin
          src |= int'(e);
          if (k == err_at + DRAIN_CYCLES) begin done = 1'b1; cause = 2; end
        end
        if (done) begin
          ex = '{cause, k, commits, src, k + RESET_CYCLES};
          q.push_back(ex);
        end
        @(negedge clk);

        if (abort && err_at != 0 && !done && k == err_at + 2) begin
          chk("drain_no_finish", longint'(bus.finish), 0);
          rst = 1'b0;
          #1;
          chk("abort_dut_rst", longint'(bus.dut_rst), 1);
          chk("abort_err_src", longint'(bus.err_src), 0);
          chk("abort_cycles",  longint'(bus.cycle_count), 0);
          chk("abort_commits", longint'(bus.commit_count), 0);
          chk("abort_finish",  longint'(bus.finish), 0);
          aborted = 1'b1;
          break;
        end
      end

      if (!aborted) begin
        waitc = 0;
        while (q.size() != 0 && waitc < 10) begin
          @(negedge clk);
          waitc++;
        end
        chk("finish_seen", q.size(), 0);
        q.delete();

        // Inputs after the run has ended must not disturb any reported value.
        repeat (3) begin
          drive(N_COMMIT'($urandom), N_ERR'($urandom), 1'($urandom), 1, 1);
          @(negedge clk);
        end
        chk("hold_finish",  longint'(bus.finish), 1);
        chk("hold_cause",   longint'(bus.end_cause), ex.cause);
        chk("hold_cycles",  longint'(bus.cycle_count), ex.cyc);
        chk("hold_commits", longint'(bus.commit_count), ex.commits);
        chk("hold_err_src", longint'(bus.err_src), ex.src);
        chk("hold_dut_rst", longint'(bus.dut_rst), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
